// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path definitions: byte width, default FIFO depth and entry width.
// Entry width follows the build option UART_RX_ERRTAG_EN (9-bit {err,data} entries when defined).
package uart_rx_fifo_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

`ifdef UART_RX_ERRTAG_EN
    localparam int ENTRY_W = BYTE_W + 1;
`else
    localparam int ENTRY_W = BYTE_W;
`endif

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side and consumer-side signals of uart_rx_fifo, grouped for port connection.
// The out_err tag is present only when UART_RX_ERRTAG_EN is defined.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] rx_data;
    logic              rx_avail;
    logic              rx_error;
    logic              rx_ack;
    logic [BYTE_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [AW:0]       level;
    logic              full;
    logic              overflow;
    logic              ferr;
    logic              clr_status;
`ifdef UART_RX_ERRTAG_EN
    logic              out_err;
`endif

    modport slave (
`ifdef UART_RX_ERRTAG_EN
        output out_err,
`endif
        input  rx_data, rx_avail, rx_error, out_ready, clr_status,
        output rx_ack, out_data, out_valid, level, full, overflow, ferr
    );

    modport master (
`ifdef UART_RX_ERRTAG_EN
        input  out_err,
`endif
        output rx_data, rx_avail, rx_error, out_ready, clr_status,
        input  rx_ack, out_data, out_valid, level, full, overflow, ferr
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers wrap modulo DEPTH (power of two).
// Reads are asynchronous from the array so a pushed word is visible one cycle after the push.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal alongside it.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures receiver bytes with a one-cycle ack, queues them, keeps sticky status.
// Build option UART_RX_ERRTAG_EN queues framing errors as tagged 0x00 entries and adds out_err.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic               r_ack;
    logic               r_overflow;
    logic               r_ferr;
    logic               w_capture;
    logic               w_ferr_evt;
    logic               w_push_req;
    logic               w_pop;
    logic               w_ovf_evt;
    logic               w_full;
    logic               w_empty;
    logic [AW:0]        w_level;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;

    // The receiver keeps its flags up until it sees the ack, so the ack itself masks a re-capture.
    assign w_capture  = (bus.rx_avail || bus.rx_error) && !r_ack;
    assign w_ferr_evt = w_capture && bus.rx_error;
    assign w_pop      = !w_empty && bus.out_ready;

`ifdef UART_RX_ERRTAG_EN
    assign w_push_req  = w_capture;
    assign w_wdata     = bus.rx_error ? {1'b1, {BYTE_W{1'b0}}} : {1'b0, bus.rx_data};
    assign bus.out_err = w_rdata[BYTE_W];
`else
    assign w_push_req  = w_capture && !bus.rx_error;
    assign w_wdata     = bus.rx_data;
`endif

    assign w_ovf_evt = w_push_req && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_pop   (bus.out_ready),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Sticky flags: a new event in the clearing cycle takes priority over clr_status.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_overflow <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_ack      <= w_capture;
            r_overflow <= w_ovf_evt  || (r_overflow && !bus.clr_status);
            r_ferr     <= w_ferr_evt || (r_ferr && !bus.clr_status);
        end
    end

    assign bus.rx_ack    = r_ack;
    assign bus.out_data  = w_rdata[BYTE_W-1:0];
    assign bus.out_valid = !w_empty;
    assign bus.level     = w_level;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.ferr      = r_ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16): directed scenarios plus randomized traffic
// compared against a queue-based model. Inputs change 1 time unit after posedge; outputs read then or at negedge.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit         mon_en   = 1'b0;
    logic [7:0] mon_q[$];
    int         mon_acks = 0;

    logic [7:0] model_q[$];
    bit         model_ovf;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid && bus.out_ready) mon_q.push_back(bus.out_data);
            if (bus.rx_ack) mon_acks++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (finished 0, need 1)");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    // Receiver model: raise avail/error, hold until ack is seen, then drop.
    task automatic send(input logic [7:0] d, input bit err = 1'b0,
                        input bit pop_too = 1'b0, input bit clr_too = 1'b0);
        bit got;
        got = 1'b0;
        bus.rx_data    = err ? 8'h00 : d;
        bus.rx_avail   = !err;
        bus.rx_error   = err;
        bus.out_ready  = pop_too;
        bus.clr_status = clr_too;
        step();
        bus.out_ready  = 1'b0;
        bus.clr_status = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_ack === 1'b1) got = 1'b1;
        end
        step();
        bus.rx_avail = 1'b0;
        bus.rx_error = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_ack: no rx_ack for byte %02h (seen 0, need 1)", d);
        end
        $display("[TB] rx  %02h err=%0b level=%0d", d, err, bus.level);
    endtask

    task automatic pop(output logic [7:0] d, output logic v);
        bus.out_ready = 1'b1;
        @(negedge clk);
        d = bus.out_data;
        v = bus.out_valid;
        step();
        bus.out_ready = 1'b0;
        $display("[TB] pop %02h valid=%0b level=%0d", d, v, bus.level);
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.rx_ack !== 1'b0)    begin n_fail++; $display("FAIL reset_ack: got %0b need 0", bus.rx_ack); end
        n_tests++; if (bus.level !== 5'd0)     begin n_fail++; $display("FAIL reset_level: got %0d need 0", bus.level); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b need 0", bus.out_valid); end
        n_tests++; if (bus.full !== 1'b0)      begin n_fail++; $display("FAIL reset_full: got %0b need 0", bus.full); end
        n_tests++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %0b need 0", bus.overflow); end
        n_tests++; if (bus.ferr !== 1'b0)      begin n_fail++; $display("FAIL reset_ferr: got %0b need 0", bus.ferr); end
    endtask

    task automatic test_stream();
        logic [7:0] exp[3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        do_reset();
        mon_q.delete();
        mon_acks = 0;
        mon_en = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rx_data  = exp[i];
            bus.rx_avail = 1'b1;
            step();
            for (int k = 0; k < 8 && bus.rx_ack !== 1'b1; k++) @(negedge clk);
            step();
            bus.rx_avail = 1'b0;
            $display("[TB] rx  %02h streamed", exp[i]);
        end
        repeat (4) step();
        bus.out_ready = 1'b0;
        mon_en = 1'b0;
        n_tests++; if (mon_q.size() != 3) begin n_fail++; $display("FAIL stream_count: got %0d need 3", mon_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (i >= mon_q.size() || mon_q[i] !== exp[i]) begin
                n_fail++; $display("FAIL stream_data[%0d]: got %02h need %02h", i, (i < mon_q.size()) ? mon_q[i] : 8'hxx, exp[i]);
            end
        end
        n_tests++; if (mon_acks != 3)      begin n_fail++; $display("FAIL stream_acks: got %0d need 3", mon_acks); end
        n_tests++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL stream_level: got %0d need 0", bus.level); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic       v;
        do_reset();
        for (int i = 0; i <= 16; i++) send(8'(i));
        n_tests++; if (bus.full !== 1'b1)     begin n_fail++; $display("FAIL ovf_full: got %0b need 1", bus.full); end
        n_tests++; if (bus.level !== 5'd16)   begin n_fail++; $display("FAIL ovf_level: got %0d need 16", bus.level); end
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b need 1", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            pop(d, v);
            n_tests++;
            if (v !== 1'b1 || d !== 8'(i)) begin
                n_fail++; $display("FAIL ovf_pop[%0d]: got %02h/v%0b need %02h/v1", i, d, v, 8'(i));
            end
        end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_lost: out_valid %0b need 0 (0x10 dropped)", bus.out_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] d, first, last;
        logic       v;
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i));
        send(8'hAA, 1'b0, 1'b1);
        n_tests++; if (bus.level !== 5'd16)   begin n_fail++; $display("FAIL fullpop_level: got %0d need 16", bus.level); end
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %0b need 0", bus.overflow); end
        first = 8'hxx; last = 8'hxx;
        for (int i = 0; i < 16; i++) begin
            pop(d, v);
            if (i == 0) first = d;
            last = d;
        end
        n_tests++; if (first !== 8'h01) begin n_fail++; $display("FAIL fullpop_first: got %02h need 01", first); end
        n_tests++; if (last !== 8'hAA)  begin n_fail++; $display("FAIL fullpop_last: got %02h need AA", last); end
    endtask

    task automatic test_ferr();
        do_reset();
        mon_acks = 0;
        mon_en = 1'b1;
        send(8'h00, 1'b1);
        step();
        step();
        mon_en = 1'b0;
        n_tests++; if (mon_acks != 1)      begin n_fail++; $display("FAIL ferr_acks: got %0d need 1", mon_acks); end
        n_tests++; if (bus.ferr !== 1'b1)  begin n_fail++; $display("FAIL ferr_flag: got %0b need 1", bus.ferr); end
`ifdef UART_RX_ERRTAG_EN
        n_tests++; if (bus.level !== 5'd1)     begin n_fail++; $display("FAIL ferr_level: got %0d need 1", bus.level); end
        n_tests++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL ferr_data: got %02h need 00", bus.out_data); end
        n_tests++; if (bus.out_err !== 1'b1)   begin n_fail++; $display("FAIL ferr_tag: got %0b need 1", bus.out_err); end
`else
        n_tests++; if (bus.level !== 5'd0)     begin n_fail++; $display("FAIL ferr_level: got %0d need 0", bus.level); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %0b need 0", bus.out_valid); end
`endif
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        for (int i = 0; i < 5; i++) send(8'($urandom));
        n_tests++; if (bus.level !== 5'd5) begin n_fail++; $display("FAIL rstmid_pre: got %0d need 5", bus.level); end
        reset = 1'b1;
        bus.rx_data  = 8'h55;
        bus.rx_avail = 1'b1;
        step();
        n_tests++; if (bus.level !== 5'd0)     begin n_fail++; $display("FAIL rstmid_level: got %0d need 0", bus.level); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b need 0", bus.out_valid); end
        reset = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.rx_ack === 1'b1) got = 1'b1;
        end
        step();
        bus.rx_avail = 1'b0;
        $display("[TB] rx  55 pending across reset");
        n_tests++; if (!got) begin n_fail++; $display("FAIL rstmid_ack: seen 0 need 1"); end
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
            n_fail++; $display("FAIL rstmid_data: got %02h/v%0b need 55/v1", bus.out_data, bus.out_valid);
        end
    endtask

    task automatic test_clr_status();
        do_reset();
        for (int i = 0; i < 16; i++) send(8'($urandom));
        send(8'h77, 1'b0, 1'b0, 1'b1);
        n_tests++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL clr_setwins: got %0b need 1", bus.overflow); end
        send(8'h00, 1'b1);
        n_tests++; if (bus.ferr !== 1'b1)     begin n_fail++; $display("FAIL clr_ferrset: got %0b need 1", bus.ferr); end
        bus.clr_status = 1'b1;
        step();
        bus.clr_status = 1'b0;
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %0b need 0", bus.overflow); end
        n_tests++; if (bus.ferr !== 1'b0)     begin n_fail++; $display("FAIL clr_ferr: got %0b need 0", bus.ferr); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       v;
        int         sz;
        do_reset();
        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 99) < 55) begin
                d = 8'($urandom);
                send(d);
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else model_ovf = 1'b1;
            end else begin
                pop(d, v);
                n_tests++;
                if (model_q.size() > 0) begin
                    if (v !== 1'b1 || d !== model_q[0]) begin
                        n_fail++; $display("FAIL rand_pop[%0d]: got %02h/v%0b need %02h/v1", it, d, v, model_q[0]);
                    end
                    void'(model_q.pop_front());
                end else if (v !== 1'b0) begin
                    n_fail++; $display("FAIL rand_empty[%0d]: out_valid %0b need 0", it, v);
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.clr_status = 1'b1;
                step();
                bus.clr_status = 1'b0;
                model_ovf = 1'b0;
            end
            sz = model_q.size();
            n_tests++; if (bus.level !== 5'(sz))            begin n_fail++; $display("FAIL rand_level[%0d]: got %0d need %0d", it, bus.level, sz); end
            n_tests++; if (bus.full !== (sz == DEPTH))      begin n_fail++; $display("FAIL rand_full[%0d]: got %0b need %0b", it, bus.full, sz == DEPTH); end
            n_tests++; if (bus.overflow !== model_ovf)      begin n_fail++; $display("FAIL rand_ovf[%0d]: got %0b need %0b", it, bus.overflow, model_ovf); end
        end
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.rx_avail   = 1'b0;
        bus.rx_error   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.clr_status = 1'b0;
        model_ovf      = 1'b0;
        #1;
        test_reset();
        test_stream();
        test_overflow();
        test_full_pop();
        test_ferr();
        test_reset_mid();
        test_clr_status();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, default 16; FIFO entries, power of two, 2..256.
REQ-002 Derived constant: AW = log2(DEPTH); not a user parameter.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_avail  input  1  receiver holds a valid byte; level until acknowledged.
REQ-007 rx_error  input  1  receiver framing error; level until acknowledged.
REQ-008 rx_ack  output  1  registered one-cycle acknowledge to the receiver.
REQ-009 out_data  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer pops head when out_valid=1.
REQ-012 level  output  AW+1  current occupancy, 0..DEPTH.
REQ-013 full  output  1  level == DEPTH.
REQ-014 overflow  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-015 ferr  output  1  sticky: a framing error was reported.
REQ-016 clr_status  input  1  one-cycle pulse clearing overflow and ferr.

Function
REQ-017 Capture event when (rx_avail or rx_error) and rx_ack==0; rx_ack is high in the cycle after each capture event, for exactly one cycle.
REQ-018 The rx_ack==0 qualifier blocks a second capture while the receiver is still clearing rx_avail/rx_error; each received byte produces exactly one capture event.
REQ-019 Capture with rx_avail=1, rx_error=0, not full: rx_data is pushed; level increments the next cycle.
REQ-020 Capture with full and no pop in the same cycle: byte dropped, rx_ack still issued, overflow set.
REQ-021 Capture with full and a pop in the same cycle: push accepted, level stays DEPTH, overflow unchanged.
REQ-022 Pop occurs when out_valid and out_ready; out_data shows the next entry in the following cycle.
REQ-023 Simultaneous push and pop when not empty: level unchanged.
REQ-024 Push into an empty FIFO: out_valid and out_data valid in the next cycle (1-cycle latency).
REQ-025 out_ready while empty is ignored; no underflow, level stays 0.
REQ-026 Read and write pointers are AW bits and wrap modulo DEPTH; level is computed at AW+1 bits.
REQ-027 clr_status coinciding with a new overflow or ferr event: the set wins.
REQ-028 out_data is don't-care while out_valid=0.

Reset
REQ-029 On reset: rx_ack=0, level=0, out_valid=0, full=0, overflow=0, ferr=0, and both pointers=0.
REQ-030 Reset asserted mid-operation discards all FIFO contents; a receiver byte pending at reset release is captured normally afterwards.

Configuration
REQ-031 Macro UART_RX_ERRTAG_EN defined: each entry is 9 bits {err,data}; a framing-error capture pushes data 0x00 with err=1, and an output out_err (1 bit) shows the head entry's tag.
REQ-032 Macro UART_RX_ERRTAG_EN undefined: a framing-error capture pushes nothing, only sets ferr; out_err port is absent.
REQ-033 In both builds, a framing-error capture sets ferr and issues rx_ack.

Structure
REQ-034 A shared UART definitions package holds the byte width (8), the default DEPTH, and the entry width selected by UART_RX_ERRTAG_EN.
REQ-035 Storage and pointers live in one sub-module, sync_fifo (parameters WIDTH, DEPTH, with push/pop/full/empty/level); uart_rx_fifo holds the capture/ack logic and the sticky flags.

Verification
REQ-036 Bytes 0x41,0x42,0x43 delivered, out_ready=1 -> out_data sequence 0x41,0x42,0x43; exactly 3 rx_ack pulses; level returns to 0.
REQ-037 DEPTH=16, out_ready=0, 17 bytes 0x00..0x10 -> full=1 and level=16; overflow=1; popped data 0x00..0x0F; 0x10 is lost.
REQ-038 Full FIFO, new byte 0xAA arriving in the same cycle as a pop -> level stays 16, overflow=0, 0xAA is the last entry read.
REQ-039 rx_error held 3 cycles -> one rx_ack and ferr=1; with UART_RX_ERRTAG_EN, one entry 0x00 with out_err=1; without it, level=0.
REQ-040 Reset with level=5 -> next cycle level=0, out_valid=0; a subsequent byte 0x55 reads back as 0x55.
REQ-041 clr_status pulsed in the same cycle as an overflow drop -> overflow remains 1; a clr_status pulse alone -> overflow=0, ferr=0.
